// File: rtl/cdb_writeback_scheduler.sv
// Per-unit result holding FIFOs feeding a single registered common-data-bus broadcast port.
// Optional head aging with promoted-set override is compiled in with CDB_SCHED_AGING_EN.
module cdb_writeback_scheduler #(
   parameter  int ISSUER         = 4,
   parameter  int ROB_ENTRY      = 4,
   parameter  int DATA_WIDTH     = 32,
   parameter  int FIFO_DEPTH     = 2,
   parameter  int AGE_LIMIT      = 8,
   localparam int ROB_ENTRY_LOG2 = $clog2(ROB_ENTRY)
) (
   input  logic                             CLK,
   input  logic                             RSTN,
   input  logic [ISSUER-1:0]                eu_valid,
   output logic [ISSUER-1:0]                eu_ready,
   input  logic [ISSUER*ROB_ENTRY_LOG2-1:0] eu_rob_id,
   input  logic [ISSUER*DATA_WIDTH-1:0]     eu_data,
   input  logic                             cdb_stall,
   input  logic                             flush,
   output logic                             cdb_valid,
   output logic [ISSUER-1:0]                cdb_grant,
   output logic [ROB_ENTRY_LOG2-1:0]        cdb_rob_id,
   output logic [DATA_WIDTH-1:0]            cdb_data
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int ENT_W = ROB_ENTRY_LOG2 + DATA_WIDTH;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
`ifdef CDB_SCHED_AGING_EN
   localparam int AGE_W = $clog2(AGE_LIMIT + 1);
   localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(AGE_LIMIT);
`endif

   logic [ISSUER-1:0] enq;
   logic [ISSUER-1:0] cand;
   logic [ISSUER-1:0] promoted;
   logic [ISSUER-1:0] pick;
   logic [ISSUER-1:0] grant_d;
   logic [ENT_W-1:0]  head [ISSUER];
   logic [ENT_W-1:0]  sel_ent;

   logic                      cdb_valid_q, cdb_valid_d;
   logic [ISSUER-1:0]         cdb_grant_q, cdb_grant_d;
   logic [ROB_ENTRY_LOG2-1:0] cdb_rob_id_q, cdb_rob_id_d;
   logic [DATA_WIDTH-1:0]     cdb_data_q, cdb_data_d;

   for (genvar gi = 0; gi < ISSUER; gi++) begin : g_unit
      logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
      logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
      logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
      logic [CNT_W-1:0] count_q, count_d;

      // Ready comes from the registered count only, so a full FIFO never accepts even while draining.
      assign eu_ready[gi] = (count_q != FULL_CNT);
      assign enq[gi]      = eu_valid[gi] & eu_ready[gi] & ~flush;
      assign cand[gi]     = (count_q != '0);
      assign head[gi]     = mem_q[rd_ptr_q];

      always_comb begin
         rd_ptr_d = rd_ptr_q;
         wr_ptr_d = wr_ptr_q;
         count_d  = count_q;
         if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
         end else begin
            if (enq[gi])     wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (grant_d[gi]) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (enq[gi] && !grant_d[gi])      count_d = count_q + CNT_W'(1);
            else if (!enq[gi] && grant_d[gi]) count_d = count_q - CNT_W'(1);
         end
      end

      always_ff @(posedge CLK or negedge RSTN) begin
         if (!RSTN) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
         end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
         end
      end

      always_ff @(posedge CLK) begin
         if (enq[gi])
            mem_q[wr_ptr_q] <= {eu_rob_id[gi*ROB_ENTRY_LOG2 +: ROB_ENTRY_LOG2],
                                eu_data[gi*DATA_WIDTH +: DATA_WIDTH]};
      end

`ifdef CDB_SCHED_AGING_EN
      logic [AGE_W-1:0] age_q, age_d;

      always_comb begin
         age_d = age_q;
         if (flush || !cand[gi] || grant_d[gi]) age_d = '0;
         else if (age_q != AGE_MAX)             age_d = age_q + AGE_W'(1);
      end

      always_ff @(posedge CLK or negedge RSTN) begin
         if (!RSTN) age_q <= '0;
         else       age_q <= age_d;
      end

      assign promoted[gi] = (age_q == AGE_MAX);
`else
      assign promoted[gi] = 1'b0;
`endif
   end

   // Lowest set bit of the active set wins; promoted heads pre-empt plain priority.
   always_comb begin
      pick    = (|(promoted & cand)) ? (promoted & cand) : cand;
      grant_d = '0;
      if (!cdb_stall && !flush) grant_d = pick & (~pick + ISSUER'(1));
      sel_ent = '0;
      for (int i = 0; i < ISSUER; i++) begin
         if (grant_d[i]) sel_ent = head[i];
      end
   end

   always_comb begin
      cdb_valid_d  = |grant_d;
      cdb_grant_d  = grant_d;
      cdb_rob_id_d = cdb_rob_id_q;
      cdb_data_d   = cdb_data_q;
      if (|grant_d) {cdb_rob_id_d, cdb_data_d} = sel_ent;
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         cdb_valid_q  <= 1'b0;
         cdb_grant_q  <= '0;
         cdb_rob_id_q <= '0;
         cdb_data_q   <= '0;
      end else begin
         cdb_valid_q  <= cdb_valid_d;
         cdb_grant_q  <= cdb_grant_d;
         cdb_rob_id_q <= cdb_rob_id_d;
         cdb_data_q   <= cdb_data_d;
      end
   end

   assign cdb_valid  = cdb_valid_q;
   assign cdb_grant  = cdb_grant_q;
   assign cdb_rob_id = cdb_rob_id_q;
   assign cdb_data   = cdb_data_q;

endmodule
